motor_pwm_driver: RTL and testbench

MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

---
 rtl/motor_pkg.sv | 16 +
 rtl/motor_ramp_channel.sv | 83 ++++++++
 rtl/motor_pwm_driver.sv | 60 ++++++
 tb/tb_motor_pwm_driver.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the motor PWM driver: channel state encoding and
// default parameter values.
package motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } chan_state_t;

  localparam int DEF_PWM_BITS  = 8;
  localparam int DEF_RAMP_STEP = 64;
  localparam int DEF_MAX_DUTY  = 255;

endpackage

// File: rtl/motor_ramp_channel.sv
// One motor channel: ramp FSM, duty register and zero-lag PWM output register.
//
// state        | meaning
// -------------+----------------------------------------------
// ST_IDLE      | duty 0, motor off
// ST_RAMP_UP   | duty climbing by RAMP_STEP per period
// ST_RUN       | duty at MAX_DUTY
// ST_RAMP_DOWN | duty falling by RAMP_STEP per period
module motor_ramp_channel
  import motor_pkg::*;
#(
  parameter int PWM_BITS  = DEF_PWM_BITS,
  parameter int RAMP_STEP = DEF_RAMP_STEP,
  parameter int MAX_DUTY  = DEF_MAX_DUTY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                boundary,
  input  logic [PWM_BITS-1:0] cnt_nxt,
  output logic                pwm,
  output logic                busy
);

  localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(RAMP_STEP);
  localparam logic [PWM_BITS-1:0] STEP_N = PWM_BITS'(RAMP_STEP);
  localparam logic [PWM_BITS:0]   MAX_W  = (PWM_BITS+1)'(MAX_DUTY);
  localparam logic [PWM_BITS-1:0] MAX_N  = PWM_BITS'(MAX_DUTY);

  chan_state_t         state;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS:0]   sum;
  logic [PWM_BITS-1:0] duty_up;
  logic [PWM_BITS-1:0] duty_dn;
  chan_state_t         up_state;
  chan_state_t         dn_state;

  // Extra bit on the sum so a step past the ceiling clamps instead of wrapping.
  assign sum      = {1'b0, duty} + STEP_W;
  assign duty_up  = (sum >= MAX_W) ? MAX_N : sum[PWM_BITS-1:0];
  assign duty_dn  = ({1'b0, duty} > STEP_W) ? (duty - STEP_N) : '0;
  assign up_state = (duty_up == MAX_N) ? ST_RUN : ST_RAMP_UP;
  assign dn_state = (duty_dn == '0) ? ST_IDLE : ST_RAMP_DOWN;

  assign busy = (state == ST_RAMP_UP) || (state == ST_RAMP_DOWN);

  // pwm is loaded with the compare against next-cycle count and duty, so it
  // lines up with cnt in the cycle it is visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      duty  <= '0;
      pwm   <= 1'b0;
    end else begin
      pwm <= (cnt_nxt < duty);
      if (boundary) begin
        case (state)
          ST_IDLE: begin
            if (req) begin
              duty <= duty_up; state <= up_state; pwm <= (cnt_nxt < duty_up);
            end
          end
          ST_RAMP_UP, ST_RAMP_DOWN: begin
            if (req) begin
              duty <= duty_up; state <= up_state; pwm <= (cnt_nxt < duty_up);
            end else begin
              duty <= duty_dn; state <= dn_state; pwm <= (cnt_nxt < duty_dn);
            end
          end
          ST_RUN: begin
            if (!req) begin
              duty <= duty_dn; state <= dn_state; pwm <= (cnt_nxt < duty_dn);
            end
          end
          default: begin
            duty <= '0; state <= ST_IDLE; pwm <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Two-channel ramped PWM motor driver: shared period counter and boundary
// strobe feeding two independent ramp channels.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int PWM_BITS  = DEF_PWM_BITS,
  parameter int RAMP_STEP = DEF_RAMP_STEP,
  parameter int MAX_DUTY  = DEF_MAX_DUTY
) (
  input  logic clk,
  input  logic reset,
  input  logic motorLeft,
  input  logic motorRight,
  output logic pwmLeft,
  output logic pwmRight,
  output logic busyLeft,
  output logic busyRight
);

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] cnt_nxt;
  logic                boundary;

  assign cnt_nxt  = cnt + 1'b1;
  assign boundary = (cnt == '1);

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

  motor_ramp_channel #(
    .PWM_BITS (PWM_BITS),
    .RAMP_STEP(RAMP_STEP),
    .MAX_DUTY (MAX_DUTY)
  ) u_left (
    .clk     (clk),
    .reset   (reset),
    .req     (motorLeft),
    .boundary(boundary),
    .cnt_nxt (cnt_nxt),
    .pwm     (pwmLeft),
    .busy    (busyLeft)
  );

  motor_ramp_channel #(
    .PWM_BITS (PWM_BITS),
    .RAMP_STEP(RAMP_STEP),
    .MAX_DUTY (MAX_DUTY)
  ) u_right (
    .clk     (clk),
    .reset   (reset),
    .req     (motorRight),
    .boundary(boundary),
    .cnt_nxt (cnt_nxt),
    .pwm     (pwmRight),
    .busy    (busyRight)
  );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Scoreboard bench for motor_pwm_driver: a duty-toward-target model pushes
// expected outputs per cycle; a monitor pops and compares on the falling edge.
module tb_motor_pwm_driver;

  localparam int PERIOD    = 256;
  localparam int STEP      = 64;
  localparam int MAXD      = 255;
  localparam int MAX_CYCLES = 200000;

  logic clk;
  logic reset;
  logic motorLeft;
  logic motorRight;
  logic pwmLeft;
  logic pwmRight;
  logic busyLeft;
  logic busyRight;

  motor_pwm_driver dut (
    .clk       (clk),
    .reset     (reset),
    .motorLeft (motorLeft),
    .motorRight(motorRight),
    .pwmLeft   (pwmLeft),
    .pwmRight  (pwmRight),
    .busyLeft  (busyLeft),
    .busyRight (busyRight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic pl;
    logic pr;
    logic bl;
    logic br;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  int m_cnt = 0;
  int m_duty[2] = '{0, 0};
  int n_bound = 0;

  // Each boundary moves duty one step toward the requested end of the range.
  function automatic int toward(int d, bit r);
    if (r) return (d + STEP > MAXD) ? MAXD : d + STEP;
    else   return (d - STEP < 0) ? 0 : d - STEP;
  endfunction

  task automatic tick(bit rst, bit l, bit r);
    exp_t e;
    reset      = rst;
    motorLeft  = l;
    motorRight = r;
    @(posedge clk);
    #1;
    if (rst) begin
      m_cnt   = 0;
      m_duty  = '{0, 0};
      n_cmp++;
      if ((dut.cnt !== '0) || (pwmLeft !== 1'b0) || (pwmRight !== 1'b0) ||
          (busyLeft !== 1'b0) || (busyRight !== 1'b0)) begin
        n_bad++;
        $display("FAIL reset t=%0t cnt=%0d pwmL=%b pwmR=%b busyL=%b busyR=%b",
                 $time, dut.cnt, pwmLeft, pwmRight, busyLeft, busyRight);
      end
    end else begin
      if (m_cnt == PERIOD - 1) begin
        m_duty[0] = toward(m_duty[0], l);
        m_duty[1] = toward(m_duty[1], r);
        n_bound++;
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
    e.pl = (m_cnt < m_duty[0]);
    e.pr = (m_cnt < m_duty[1]);
    e.bl = (m_duty[0] > 0) && (m_duty[0] < MAXD);
    e.br = (m_duty[1] > 0) && (m_duty[1] < MAXD);
    q.push_back(e);
    cyc++;
    if (cyc > MAX_CYCLES) begin
      n_bad++;
      $display("FAIL wait expired t=%0t after %0d cycles", $time, cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  endtask

  task automatic run(int n, bit l, bit r);
    for (int i = 0; i < n; i++) tick(1'b0, l, r);
  endtask

  task automatic run_bounds(int nb, bit l, bit r);
    int target;
    target = n_bound + nb;
    while (n_bound < target) tick(1'b0, l, r);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = q.pop_front();
      a = '{pwmLeft, pwmRight, busyLeft, busyRight};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs t=%0t {pwmL,pwmR,busyL,busyR} got=%b expected=%b",
                 $time, a, e);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    motorLeft  = 1'b1;
    motorRight = 1'b1;

    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1);

    // left ramps up to RUN, right stays off
    run_bounds(5, 1'b1, 1'b0);
    run(20, 1'b1, 1'b0);
    // ramp down to IDLE
    run_bounds(5, 1'b0, 1'b0);
    // reversal: reach 128, then drop the request
    run_bounds(2, 1'b1, 1'b0);
    run_bounds(3, 1'b0, 1'b0);
    // 10-cycle glitch well clear of any boundary
    while (m_cnt != 100) tick(1'b0, 1'b0, 1'b0);
    run(10, 1'b1, 1'b0);
    run_bounds(2, 1'b0, 1'b0);
    // both channels in lockstep, then reset while in RUN
    run_bounds(5, 1'b1, 1'b1);
    run(37, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    run_bounds(2, 1'b1, 1'b1);
    run(10, 1'b1, 1'b1);

    for (int s = 0; s < 24; s++) begin
      bit l;
      bit r;
      int len;
      l   = 1'($urandom_range(0, 1));
      r   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 600));
      if ($urandom_range(0, 15) == 0) tick(1'b1, l, r);
      run(len, l, r);
    end

    @(negedge clk);
    #1;
    if (n_cmp == 0) begin
      n_bad++;
      $display("FAIL no comparisons were made");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
